bitwise_result_checker: RTL

BITWISE_RESULT_CHECKER -- requirements
Module: bitwise_result_checker

---
 rtl/bitwise_result_checker_pkg.sv | 24 ++
 rtl/bitwise_result_checker_ref.sv | 24 ++
 rtl/bitwise_result_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bitwise_result_checker_pkg.sv
// Shared definitions for the bitwise result checker: op encodings, FSM states
// and the saturating tally helper.
package bitwise_result_checker_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int unsigned  CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/bitwise_result_checker_ref.sv
// Combinational reference for the bitwise unit: expected result from a, b, op.
module bitwise_ref_model
   import bitwise_result_checker_pkg::*;
#(
   parameter int unsigned WIDTH = 7
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] expected_o
);

   always_comb begin
      expected_o = '0;
      unique case (op_i)
         OP_AND:  expected_o = a_i & b_i;
         OP_OR:   expected_o = a_i | b_i;
         OP_XOR:  expected_o = a_i ^ b_i;
         OP_NOR:  expected_o = ~(a_i | b_i);
         default: expected_o = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_result_checker.sv
// Checks a bitwise unit's q against expected values carried through a
// LATENCY-deep pipeline; keeps saturating tallies and the first mismatch.
module bitwise_result_checker
   import bitwise_result_checker_pkg::*;
#(
   parameter int unsigned WIDTH       = 7,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned NUM_VECTORS = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [7:0]       pass_count,
   output logic [7:0]       fail_count,
   output logic [7:0]       fail_index,
   output logic [WIDTH-1:0] fail_expected,
   output logic [WIDTH-1:0] fail_actual
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
   // All stages except the head; empty means the head is the final compare.
   localparam logic [LATENCY-1:0] TAIL_MASK = '1 >> 1;

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] exp;
      logic [7:0]       idx;
   } entry_t;

   state_t           state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       pass_q, pass_d;
   logic [7:0]       fail_q, fail_d;
   logic             err_q, err_d;
   logic [7:0]       fidx_q, fidx_d;
   logic [WIDTH-1:0] fexp_q, fexp_d;
   logic [WIDTH-1:0] fact_q, fact_d;

   logic             push;
   logic             restart;
   logic             pending;
   logic [WIDTH-1:0] expected;
   entry_t           stage_q [LATENCY];
   entry_t           head;
   logic [LATENCY-1:0] vld;

   bitwise_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a_i        (a),
      .b_i        (b),
      .op_i       (op),
      .expected_o (expected)
   );

   always_ff @(posedge clk) begin
      if (reset) stage_q[0] <= '0;
      else       stage_q[0] <= {push, expected, idx_q};
   end

   for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      always_ff @(posedge clk) begin
         if (reset) stage_q[g] <= '0;
         else       stage_q[g] <= stage_q[g-1];
      end
   end

   for (genvar g = 0; g < LATENCY; g++) begin : g_vld
      assign vld[g] = stage_q[g].v;
   end

   assign head    = stage_q[LATENCY-1];
   assign pending = |(vld & TAIL_MASK);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      err_d   = err_q;
      fidx_d  = fidx_q;
      fexp_d  = fexp_q;
      fact_d  = fact_q;
      push    = 1'b0;
      restart = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               restart = 1'b1;
            end
         end
         RUN: begin
            if (in_valid) begin
               push  = 1'b1;
               idx_d = idx_q + 8'd1;
               if (idx_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!pending) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (head.v) begin
         if (q == head.exp) begin
            pass_d = sat_inc(pass_q);
         end else begin
            fail_d = sat_inc(fail_q);
            if (!err_q) begin
               err_d  = 1'b1;
               fidx_d = head.idx;
               fexp_d = head.exp;
               fact_d = q;
            end
         end
      end

      if (restart) begin
         idx_d  = '0;
         pass_d = '0;
         fail_d = '0;
         err_d  = 1'b0;
         fidx_d = '0;
         fexp_d = '0;
         fact_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         err_q   <= 1'b0;
         fidx_q  <= '0;
         fexp_q  <= '0;
         fact_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         fidx_q  <= fidx_d;
         fexp_q  <= fexp_d;
         fact_q  <= fact_d;
      end
   end

   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign done          = (state_q == DONE);
   assign error         = err_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign fail_index    = fidx_q;
   assign fail_expected = fexp_q;
   assign fail_actual   = fact_q;

endmodule
